bandpower_ch_sched: RTL and testbench
=====================================

# bandpower_ch_sched

Round-robin scheduler that shares one `bandpower` engine between `NUM_CH` independent sample channels. It buffers one sample per channel and issues samples to the engine one at a time, tagging each with its channel index. It waits for the engine's done, then returns the band powers tagged with the channel. It sits between the per-channel sample sources and the single time-multiplexed `bandpower`/sliding-DFT datapath.

## Interface
- `WIDTH`, 12, sample and band-power word width (signed).
- `BAND_NUM`, 2, number of band-power outputs from the engine.
- `NUM_CH`, 4, number of requesting channels (≥2); `CH_W = $clog2(NUM_CH)`.
- `TIMEOUT`, 255, max cycles spent in WAIT before abandoning a request.

- `i_sys_clk` in 1: the single clock.
- `i_sys_rst_n` in 1: reset, asynchronous and active-low.
- `i_x` in NUM_CH*WIDTH: packed samples; channel k in bits [k*WIDTH +: WIDTH].
- `i_valid` in NUM_CH: per-channel sample strobe.
- `o_ready` out NUM_CH: per-channel holding register empty.
- `o_eng_x` out WIDTH: sample to engine.
- `o_eng_wr` out 1: one-cycle write strobe to engine.
- `o_eng_ch` out CH_W: context/channel select to engine; stable from ISSUE through end of WAIT.
- `i_eng_y` in BAND_NUM*WIDTH: engine band powers.
- `i_eng_done` in 1: engine result valid.
- `o_y` out BAND_NUM*WIDTH: captured band powers.
- `o_y_ch` out CH_W: channel of `o_y`.
- `o_y_valid` out 1: one-cycle result strobe.
- `o_overrun` out NUM_CH: sticky per-channel dropped-sample flags.
- `o_timeout` out 1: one-cycle pulse on WAIT abandonment.

## Operation
- Holding register per channel: `full[k]`, `data[k]`. `o_ready[k] = ~full[k]`.
- Accept when `i_valid[k] & ~full[k]`. The register is full the next cycle.
- `i_valid[k]` while `full[k]` drops the sample, keeps the old data, and sets `o_overrun[k]`. The flag clears only on reset.
- FSM states: IDLE, ISSUE, WAIT, OUT.
  - IDLE: if any `full`, grant the first full channel searching from `last+1` modulo NUM_CH. Register `o_eng_ch`, `o_eng_x` and `last`, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `o_eng_wr=1` for exactly this cycle. Clear `full[grant]` at the end of the cycle. Go to WAIT and clear the timeout counter.
  - WAIT: when `i_eng_done=1`, capture `i_eng_y` into `o_y` and the grant into `o_y_ch`, then go to OUT. Otherwise increment the counter. When the counter reaches TIMEOUT-1 without done, pulse `o_timeout` and go to IDLE; the sample is lost and `o_y` is unchanged.
  - OUT: `o_y_valid=1` for one cycle, then go to IDLE.
- `i_eng_done` is ignored in every state except WAIT.
- The round-robin pointer `last` resets to NUM_CH-1, so channel 0 has first priority after reset.
- A channel may be re-accepted from the cycle after ISSUE. A new `i_valid` in the ISSUE cycle itself counts as an overrun because the register is still full.

## Timing
- Reset values:
  - State IDLE.
  - `full`=0, so `o_ready`=all ones.
  - `o_eng_wr`=0, `o_eng_x`=0, `o_eng_ch`=0.
  - `o_y`=0, `o_y_ch`=0, `o_y_valid`=0.
  - `o_overrun`=0, `o_timeout`=0.
  - `last`=NUM_CH-1.
- All outputs are registered.
- Sample accepted at cycle t with the FSM in IDLE:
  - Grant at t+1.
  - `o_eng_wr` high at t+2.
  - WAIT from t+3.
- Done first seen at cycle d in WAIT: `o_y_valid` high at d+1, and the FSM is back in IDLE at d+2.
- Back-to-back grants: with engine done in the first WAIT cycle, each request takes 4 cycles (IDLE, ISSUE, WAIT, OUT).
- The timeout pulse comes exactly TIMEOUT cycles after entering WAIT.
- Reset asserted mid-operation clears everything immediately, including pending samples and the sticky flags. No `o_eng_wr` or `o_y_valid` is produced until new samples arrive.

## Test plan
- Single sample `i_valid[2]=1`, `i_x[2]=0x005` at t, with the engine answering done 3 cycles after wr and `i_eng_y={12'h010,12'h020}`:
  - `o_eng_wr` at t+2 with `o_eng_x=0x005` and `o_eng_ch=2`.
  - `o_y_valid` at t+6 with `o_y_ch=2` and `o_y` equal to the engine words.
- All four channels valid in the same cycle with samples 1, 2, 3, 4 → engine writes in channel order 0, 1, 2, 3 with matching `o_eng_x`. A further sample on channels 0 and 3 then serves channel 0 before channel 3.
- Channel 1 sample accepted, then a second `i_valid[1]` before its ISSUE → `o_overrun[1]=1` (sticky) and the engine still receives the first value.
- Engine never asserts done with TIMEOUT=8 → `o_timeout` pulses 8 cycles after WAIT entry, with no `o_y_valid` and `o_y` unchanged. The next pending channel is then issued.
- `i_eng_done` held high during IDLE/ISSUE → no `o_y_valid` until WAIT is entered. Done in the first WAIT cycle gives `o_y_valid` one cycle later.
- Drive `i_sys_rst_n` low during WAIT with channels 2 and 3 full → all outputs return to their reset values asynchronously and `o_ready`=4'b1111. After release there is no engine write until new `i_valid`.

Source files
------------

// File: rtl/bandpower_ch_sched.sv
// rtl/bandpower_ch_sched.sv - round-robin scheduler sharing one bandpower engine across channels
// Buffers one sample per channel, issues them to the engine in turn and tags results with the channel.
module bandpower_ch_sched #(
  parameter int WIDTH    = 12,
  parameter int BAND_NUM = 2,
  parameter int NUM_CH   = 4,
  parameter int TIMEOUT  = 255,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_rst_n,
  input  logic [NUM_CH*WIDTH-1:0]   i_x,
  input  logic [NUM_CH-1:0]         i_valid,
  output logic [NUM_CH-1:0]         o_ready,
  output logic [WIDTH-1:0]          o_eng_x,
  output logic                      o_eng_wr,
  output logic [CH_W-1:0]           o_eng_ch,
  input  logic [BAND_NUM*WIDTH-1:0] i_eng_y,
  input  logic                      i_eng_done,
  output logic [BAND_NUM*WIDTH-1:0] o_y,
  output logic [CH_W-1:0]           o_y_ch,
  output logic                      o_y_valid,
  output logic [NUM_CH-1:0]         o_overrun,
  output logic                      o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_e;

  state_e                    state_q, state_d;
  logic [NUM_CH-1:0]         full_q, overrun_q;
  logic [WIDTH-1:0]          data_q [NUM_CH];
  logic [CH_W-1:0]           last_q, last_d;
  logic [CH_W-1:0]           eng_ch_q, eng_ch_d;
  logic [WIDTH-1:0]          eng_x_q, eng_x_d;
  logic                      eng_wr_q, eng_wr_d;
  logic [BAND_NUM*WIDTH-1:0] y_q, y_d;
  logic [CH_W-1:0]           y_ch_q, y_ch_d;
  logic                      y_valid_q, y_valid_d;
  logic                      timeout_q, timeout_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      found;
  logic [CH_W-1:0]           grant;
  logic [CH_W-1:0]           idx;
  logic                      clr_full;

  // First full channel after the one served last, wrapping modulo NUM_CH.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((int'(last_q) + i) % NUM_CH);
      if (!found && full_q[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    eng_ch_d  = eng_ch_q;
    eng_x_d   = eng_x_q;
    eng_wr_d  = 1'b0;
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    clr_full  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_ISSUE;
          last_d   = grant;
          eng_ch_d = grant;
          eng_x_d  = data_q[grant];
          eng_wr_d = 1'b1;
        end
      end
      S_ISSUE: begin
        clr_full = 1'b1;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // Done wins over timeout when both land on the final wait cycle.
        if (i_eng_done) begin
          y_d       = i_eng_y;
          y_ch_d    = eng_ch_q;
          y_valid_d = 1'b1;
          state_d   = S_OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= CH_W'(NUM_CH - 1);
      eng_ch_q  <= '0;
      eng_x_q   <= '0;
      eng_wr_q  <= 1'b0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      eng_ch_q  <= eng_ch_d;
      eng_x_q   <= eng_x_d;
      eng_wr_q  <= eng_wr_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // A strobe on a full register is dropped and flagged; the clear at end of ISSUE
  // can never coincide with an accept because the register is still full then.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      full_q    <= '0;
      overrun_q <= '0;
      for (int k = 0; k < NUM_CH; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_valid[k]) begin
          if (full_q[k]) begin
            overrun_q[k] <= 1'b1;
          end else begin
            full_q[k] <= 1'b1;
            data_q[k] <= i_x[k*WIDTH +: WIDTH];
          end
        end
        if (clr_full && (eng_ch_q == CH_W'(k))) full_q[k] <= 1'b0;
      end
    end
  end

  assign o_ready   = ~full_q;
  assign o_eng_x   = eng_x_q;
  assign o_eng_wr  = eng_wr_q;
  assign o_eng_ch  = eng_ch_q;
  assign o_y       = y_q;
  assign o_y_ch    = y_ch_q;
  assign o_y_valid = y_valid_q;
  assign o_overrun = overrun_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_bandpower_ch_sched.sv
// tb/tb_bandpower_ch_sched.sv - randomized bench for bandpower_ch_sched against a request-timeline model
// The model tracks pending samples and schedules each request's grant/write/result/timeout cycles.
module tb_bandpower_ch_sched;

  localparam int WIDTH    = 12;
  localparam int BAND_NUM = 2;
  localparam int NUM_CH   = 4;
  localparam int TIMEOUT  = 8;
  localparam int CH_W     = 2;
  localparam int YW       = BAND_NUM * WIDTH;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH*WIDTH-1:0] x_in = '0;
  logic [NUM_CH-1:0]       valid_in = '0;
  logic [NUM_CH-1:0]       ready;
  logic [WIDTH-1:0]        eng_x;
  logic                    eng_wr;
  logic [CH_W-1:0]         eng_ch;
  logic [YW-1:0]           eng_y = '0;
  logic                    eng_done = 1'b0;
  logic [YW-1:0]           y;
  logic [CH_W-1:0]         y_ch;
  logic                    y_valid;
  logic [NUM_CH-1:0]       overrun;
  logic                    timeout;

  always #5 clk = ~clk;

  bandpower_ch_sched #(
    .WIDTH(WIDTH), .BAND_NUM(BAND_NUM), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_x(x_in), .i_valid(valid_in),
    .o_ready(ready), .o_eng_x(eng_x), .o_eng_wr(eng_wr), .o_eng_ch(eng_ch),
    .i_eng_y(eng_y), .i_eng_done(eng_done), .o_y(y), .o_y_ch(y_ch),
    .o_y_valid(y_valid), .o_overrun(overrun), .o_timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pending samples and the timeline of the request currently being served.
  bit [NUM_CH-1:0]  m_full, m_ovr;
  logic [WIDTH-1:0] m_data [NUM_CH];
  int m_last, cyc, free_at, wr_cyc, clr_cyc, wait_start, wait_end, done_cyc, yv_cyc, to_cyc, pend_ch;
  int               e_eng_ch, e_y_ch;
  logic [WIDTH-1:0] e_eng_x;
  logic [YW-1:0]    e_y;

  task automatic model_reset();
    m_full = '0;
    m_ovr  = '0;
    for (int k = 0; k < NUM_CH; k++) m_data[k] = '0;
    m_last = NUM_CH - 1;
    cyc = 0; free_at = 0; wr_cyc = -1; clr_cyc = -1; wait_start = -1; wait_end = -2;
    done_cyc = -1; yv_cyc = -1; to_cyc = -1; pend_ch = 0;
    e_eng_ch = 0; e_y_ch = 0; e_eng_x = '0; e_y = '0;
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0] exp_ready;
    logic [NUM_CH-1:0] exp_ovr;
    exp_ready = ~m_full;
    exp_ovr   = m_ovr;
    chk("ready",   ready,   exp_ready);
    chk("overrun", overrun, exp_ovr);
    chk("eng_wr",  eng_wr,  (cyc == wr_cyc));
    chk("eng_ch",  eng_ch,  e_eng_ch);
    chk("eng_x",   eng_x,   e_eng_x);
    chk("y_valid", y_valid, (cyc == yv_cyc));
    chk("y",       y,       e_y);
    chk("y_ch",    y_ch,    e_y_ch);
    chk("timeout", timeout, (cyc == to_cyc));
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    valid_in = '0;
    eng_done = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cycle_step(input int pct);
    logic [NUM_CH-1:0]       v;
    logic [NUM_CH*WIDTH-1:0] xv;
    logic [YW-1:0]           yv;
    logic                    d;
    int                      g, lat;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();

    for (int k = 0; k < NUM_CH; k++) begin
      v[k] = ($urandom_range(0, 99) < pct);
      xv[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    yv = YW'($urandom);
    if (cyc >= wait_start && cyc <= wait_end) d = (cyc == done_cyc);
    else d = 1'($urandom_range(0, 1));
    valid_in = v;
    x_in     = xv;
    eng_y    = yv;
    eng_done = d;

    if (cyc == done_cyc) begin
      e_y    = yv;
      e_y_ch = pend_ch;
    end
    if (cyc >= free_at && m_full != '0) begin
      g = -1;
      for (int i = 1; i <= NUM_CH; i++)
        if (g < 0 && m_full[(m_last + i) % NUM_CH]) g = (m_last + i) % NUM_CH;
      m_last     = g;
      pend_ch    = g;
      e_eng_ch   = g;
      e_eng_x    = m_data[g];
      wr_cyc     = cyc + 1;
      clr_cyc    = cyc + 1;
      wait_start = cyc + 2;
      lat = $urandom_range(0, TIMEOUT + 1);
      if (lat < TIMEOUT) begin
        done_cyc = wait_start + lat;
        wait_end = done_cyc;
        yv_cyc   = done_cyc + 1;
        to_cyc   = -1;
        free_at  = done_cyc + 2;
      end else begin
        done_cyc = -1;
        wait_end = wait_start + TIMEOUT - 1;
        to_cyc   = wait_start + TIMEOUT;
        yv_cyc   = -1;
        free_at  = to_cyc;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (v[k]) begin
        if (m_full[k]) m_ovr[k] = 1'b1;
        else begin
          m_full[k] = 1'b1;
          m_data[k] = xv[k*WIDTH +: WIDTH];
        end
      end
    end
    if (cyc == clr_cyc) m_full[pend_ch] = 1'b0;
  endtask

  initial begin
    bit hit;
    apply_reset();
    repeat (600) cycle_step(30);
    repeat (300) cycle_step(85);
    hit = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      cycle_step(60);
      if (cyc >= wait_start && cyc <= wait_end && m_full != '0) hit = 1'b1;
    end
    chk("reset_window_found", hit, 1'b1);
    @(negedge clk);
    apply_reset();
    repeat (20) cycle_step(0);
    repeat (600) cycle_step(15);
    repeat (200) cycle_step(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
